glyph_dma_sched: RTL and testbench

- Per-line scheduler that shares the single greeting ROM and the single font ROM among SPR_CNT glyph sprites.
- On each `line` strobe it runs two phases:
  - fetches the row's code points from the greeting ROM;
  - issues font ROM reads for each sprite, asserting that sprite's one-cycle DMA slot exactly when its glyph line is on the font ROM output.
- It also owns the greeting selector, which advances the message every MSG_CHG frames.
- It sits between display timing, both rom_sync instances and the sprite array.

---
 rtl/glyph_dma_sched.sv | 196 +++++++++++++++++++
 tb/tb_glyph_dma_sched.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/glyph_dma_sched.sv
// glyph_dma_sched
//   Per-line scheduler sharing one greeting ROM and one font ROM among
//   SPR_CNT glyph sprites. On each line strobe it fetches the row's
//   code points, then issues one font ROM read per sprite and pulses that
//   sprite's one-cycle DMA slot while its glyph line sits on the font ROM
//   output. Also owns the greeting selector (advances every MSG_CHG frames).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for the line strobe; ROM addresses hold their last values
//   CP    | stepping greet_addr and capturing code points from greet_data
//   GLYPH | issuing font_addr per sprite and strobing spr_fdma one-hot
//
// Ports
//   clk_pix, rst_pix_n     : pixel clock, synchronous active-low reset
//   frame, line            : start-of-frame / start-of-line strobes
//   sy                     : current screen line (signed), sampled on the line strobe
//   greet_addr, greet_data : greeting ROM address (registered) / data (1-cycle ROM)
//   font_addr              : font ROM address (registered)
//   glyph_line             : packed per-sprite glyph line, sprite i at [i*GL_W +: GL_W]
//   spr_fdma               : one-hot per-sprite DMA slot strobes
//   greeting               : current message index
//   busy, overrun          : schedule in progress / sticky line-while-busy flag
module glyph_dma_sched #(
  parameter int CORDW        = 16,
  parameter int SPR_CNT      = 8,
  parameter int GREET_MSGS   = 32,
  parameter int GREET_LENGTH = 16,
  parameter int MSG_CHG      = 80,
  parameter int LINE2        = 240,
  parameter int CP_START     = 'h20,
  parameter int FONT_GLYPHS  = 64,
  parameter int FONT_HEIGHT  = 8,
  parameter int GA_W         = $clog2(GREET_MSGS*GREET_LENGTH),
  parameter int CP_W         = 7,
  parameter int FA_W         = $clog2(FONT_GLYPHS*FONT_HEIGHT),
  parameter int GL_W         = $clog2(FONT_HEIGHT)
) (
  input  logic                          clk_pix,
  input  logic                          rst_pix_n,
  input  logic                          frame,
  input  logic                          line,
  input  logic signed [CORDW-1:0]       sy,
  output logic [GA_W-1:0]               greet_addr,
  input  logic [CP_W-1:0]               greet_data,
  output logic [FA_W-1:0]               font_addr,
  input  logic [SPR_CNT*GL_W-1:0]       glyph_line,
  output logic [SPR_CNT-1:0]            spr_fdma,
  output logic [$clog2(GREET_MSGS)-1:0] greeting,
  output logic                          busy,
  output logic                          overrun
);

  localparam int GS_W   = $clog2(GREET_MSGS);
  localparam int LAST   = 2*SPR_CNT + 3;
  localparam int STEP_W = $clog2(LAST + 1);
  localparam int SI_W   = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1;
  localparam int FC_W   = (MSG_CHG > 1) ? $clog2(MSG_CHG) : 1;

  // Edge indices (E0 = edge that accepts the line strobe) at which each action happens.
  localparam logic [STEP_W-1:0] K_ADDR_END = STEP_W'(SPR_CNT - 1);
  localparam logic [STEP_W-1:0] K_CAP0     = STEP_W'(2);
  localparam logic [STEP_W-1:0] K_CAP_END  = STEP_W'(SPR_CNT + 1);
  localparam logic [STEP_W-1:0] K_FONT0    = STEP_W'(SPR_CNT + 1);
  localparam logic [STEP_W-1:0] K_FONT_END = STEP_W'(2*SPR_CNT);
  localparam logic [STEP_W-1:0] K_DMA0     = STEP_W'(SPR_CNT + 2);
  localparam logic [STEP_W-1:0] K_DMA_END  = STEP_W'(2*SPR_CNT + 1);
  localparam logic [STEP_W-1:0] K_LAST     = STEP_W'(LAST);

  typedef enum logic [1:0] {IDLE, CP, GLYPH} state_t;

  state_t                        state, state_nx;
  logic [STEP_W-1:0]             left, left_nx;
  logic [STEP_W-1:0]             k_idx;
  logic [GA_W-1:0]               base_q, base_nx;
  logic [GA_W-1:0]               greet_addr_nx;
  logic [FA_W-1:0]               font_addr_nx;
  logic [SPR_CNT-1:0]            spr_fdma_nx;
  logic                          busy_nx, overrun_nx;
  logic [SPR_CNT-1:0][CP_W-1:0]  cp_q, cp_nx;
  logic [FC_W-1:0]               frame_cnt, frame_cnt_nx;
  logic [GS_W-1:0]               greeting_nx;
  logic [GA_W-1:0]               row_off, start_base;
  logic [SI_W-1:0]               cap_j, font_j, dma_j;
  logic                          start;

  // Out-of-font code points fall back to glyph 0 (space).
  function automatic logic [FA_W-1:0] glyph_base(input logic [CP_W-1:0] c);
    int ci;
    ci = int'(c);
    if (ci >= CP_START && ci < CP_START + FONT_GLYPHS)
      return FA_W'((ci - CP_START) * FONT_HEIGHT);
    return '0;
  endfunction

  // left is a down-counter of edges remaining; k_idx is the index of the next edge.
  assign k_idx      = K_LAST - left;
  assign row_off    = (sy < LINE2) ? '0 : GA_W'(GREET_LENGTH/2);
  assign start_base = GA_W'(int'(greeting) * GREET_LENGTH) + row_off;

  always_comb begin
    state_nx      = state;
    left_nx       = left;
    base_nx       = base_q;
    greet_addr_nx = greet_addr;
    font_addr_nx  = font_addr;
    spr_fdma_nx   = '0;
    busy_nx       = busy;
    overrun_nx    = overrun;
    cp_nx         = cp_q;
    frame_cnt_nx  = frame_cnt;
    greeting_nx   = greeting;
    start         = 1'b0;
    cap_j         = SI_W'(k_idx - K_CAP0);
    font_j        = SI_W'(k_idx - K_FONT0);
    dma_j         = SI_W'(k_idx - K_DMA0);

    case (state)
      IDLE: begin
        if (line) start = 1'b1;
      end
      CP, GLYPH: begin
        left_nx = left - 1'b1;
        if (k_idx != '0 && k_idx <= K_ADDR_END)
          greet_addr_nx = base_q + GA_W'(k_idx);
        if (k_idx >= K_CAP0 && k_idx <= K_CAP_END)
          cp_nx[cap_j] = greet_data;
        if (k_idx >= K_FONT0 && k_idx <= K_FONT_END)
          font_addr_nx = glyph_base(cp_q[font_j])
                       + FA_W'(glyph_line[int'(font_j)*GL_W +: GL_W]);
        if (k_idx >= K_DMA0 && k_idx <= K_DMA_END)
          spr_fdma_nx = SPR_CNT'(1) << dma_j;
        if (state == CP && k_idx == K_CAP_END)
          state_nx = GLYPH;
        if (k_idx == K_LAST) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          // A line strobe on the edge where busy falls starts the next schedule.
          if (line) start = 1'b1;
        end else if (line) begin
          overrun_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase

    if (start) begin
      state_nx      = CP;
      busy_nx       = 1'b1;
      left_nx       = STEP_W'(LAST - 1);
      base_nx       = start_base;
      greet_addr_nx = start_base;
    end

    if (frame) begin
      if (frame_cnt == FC_W'(MSG_CHG - 1)) begin
        frame_cnt_nx = '0;
        greeting_nx  = (greeting == GS_W'(GREET_MSGS - 1)) ? '0 : greeting + 1'b1;
      end else begin
        frame_cnt_nx = frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state      <= IDLE;
      left       <= '0;
      base_q     <= '0;
      greet_addr <= '0;
      font_addr  <= '0;
      spr_fdma   <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      cp_q       <= '0;
      frame_cnt  <= '0;
      greeting   <= '0;
    end else begin
      state      <= state_nx;
      left       <= left_nx;
      base_q     <= base_nx;
      greet_addr <= greet_addr_nx;
      font_addr  <= font_addr_nx;
      spr_fdma   <= spr_fdma_nx;
      busy       <= busy_nx;
      overrun    <= overrun_nx;
      cp_q       <= cp_nx;
      frame_cnt  <= frame_cnt_nx;
      greeting   <= greeting_nx;
    end
  end

endmodule

// File: tb/tb_glyph_dma_sched.sv
// tb_glyph_dma_sched
//   Directed bench for glyph_dma_sched with default parameters. A 1-cycle
//   greeting ROM model feeds greet_data; glyph_line is a fixed pattern.
module tb_glyph_dma_sched;

  logic              clk_pix = 1'b0;
  logic              rst_pix_n;
  logic              frame;
  logic              line;
  logic signed [15:0] sy;
  logic [8:0]        greet_addr;
  logic [6:0]        greet_data;
  logic [8:0]        font_addr;
  logic [23:0]       glyph_line;
  logic [7:0]        spr_fdma;
  logic [4:0]        greeting;
  logic              busy;
  logic              overrun;

  int errors = 0;
  int checks = 0;

  logic [6:0] grom [0:511];

  // sprite i glyph line = (i+3)%8; code points at addresses 0..7 below
  int exp_font [8] = '{3, 12, 269, 6, 7, 504, 129, 2};

  glyph_dma_sched dut (
    .clk_pix    (clk_pix),
    .rst_pix_n  (rst_pix_n),
    .frame      (frame),
    .line       (line),
    .sy         (sy),
    .greet_addr (greet_addr),
    .greet_data (greet_data),
    .font_addr  (font_addr),
    .glyph_line (glyph_line),
    .spr_fdma   (spr_fdma),
    .greeting   (greeting),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) greet_data <= grom[greet_addr];

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic frames(input int n);
    frame = 1'b1;
    repeat (n) step();
    frame = 1'b0;
  endtask

  task automatic run_sched(input int base, input bit chk_font, input int line_k);
    line = 1'b1;
    step();
    line = 1'b0;
    chk("e0_greet_addr", greet_addr, base);
    chk("e0_busy", busy, 1);
    for (int k = 1; k <= 19; k++) begin
      if (k == line_k) line = 1'b1;
      step();
      line = 1'b0;
      chk($sformatf("greet_addr_e%0d", k), greet_addr, base + ((k <= 7) ? k : 7));
      if (chk_font && k >= 9)
        chk($sformatf("font_addr_e%0d", k), font_addr, exp_font[(k >= 16) ? 7 : k - 9]);
      chk($sformatf("spr_fdma_e%0d", k), spr_fdma,
          (k >= 10 && k <= 17) ? (32'd1 << (k - 10)) : 32'd0);
      chk($sformatf("busy_e%0d", k), busy, (k < 19) ? 1 : 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) grom[a] = 7'h20;
    grom[0] = 7'h20; grom[1] = 7'h21; grom[2] = 7'h41; grom[3] = 7'h1F;
    grom[4] = 7'h60; grom[5] = 7'h5F; grom[6] = 7'h30; grom[7] = 7'h7F;
    glyph_line = {3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
    rst_pix_n = 1'b0;
    frame = 1'b0;
    line = 1'b0;
    sy = 16'sd0;

    repeat (3) step();
    chk("rst_greet_addr", greet_addr, 0);
    chk("rst_font_addr", font_addr, 0);
    chk("rst_spr_fdma", spr_fdma, 0);
    chk("rst_greeting", greeting, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst_pix_n = 1'b1;
    step();

    // Row 0 of message 0, full font/DMA check
    sy = 16'sd150;
    run_sched(0, 1'b1, -1);
    chk("t1_overrun", overrun, 0);
    step();

    // Greeting selector
    frames(79);
    chk("greet_after_79", greeting, 0);
    frames(1);
    chk("greet_after_80", greeting, 1);
    frames(160);
    chk("greet_after_240", greeting, 3);

    // Row 1 of message 3
    sy = 16'sd250;
    run_sched(56, 1'b0, -1);
    step();

    frames(2240);
    chk("greet_31", greeting, 31);
    frames(79);
    chk("greet_31_hold", greeting, 31);
    frames(1);
    chk("greet_wrap", greeting, 0);

    // line while busy at E5
    sy = 16'sd150;
    chk("pre_overrun", overrun, 0);
    run_sched(0, 1'b1, 5);
    chk("overrun_set", overrun, 1);
    step();
    chk("overrun_sticky", overrun, 1);

    // Reset mid-schedule at E12
    line = 1'b1;
    step();
    line = 1'b0;
    for (int k = 1; k <= 11; k++) step();
    chk("pre_rst_fdma", spr_fdma, 2);
    rst_pix_n = 1'b0;
    step();
    chk("mid_rst_fdma", spr_fdma, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_font_addr", font_addr, 0);
    rst_pix_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      chk($sformatf("post_rst_fdma_%0d", k), spr_fdma, 0);
      chk($sformatf("post_rst_busy_%0d", k), busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
